// File: rtl/zap_branch_resolve_if.sv
// Branch-resolve bundle between the ALU stage and its consumers (predictor RAM, fetch redirect).
// master drives the per-instruction inputs and flush/stall controls; slave is the resolve block.
interface zap_branch_resolve_if #(
    parameter int CNT_W = 32
);
    logic             i_clear_from_writeback;
    logic             i_data_stall;
    logic             i_val;
    logic             i_is_branch;
    logic             i_cond_true;
    logic             i_thumb;
    logic [31:0]      i_pc;
    logic [31:0]      i_target;
    logic [1:0]       i_taken;

    logic             o_clear_from_alu;
    logic             o_confirm_from_alu;
    logic [31:0]      o_pc_from_alu;
    logic [1:0]       o_taken;
    logic [31:0]      o_redirect_pc;
    logic [CNT_W-1:0] o_branch_cnt;
    logic [CNT_W-1:0] o_mispredict_cnt;

    modport master (
        output i_clear_from_writeback, i_data_stall, i_val, i_is_branch, i_cond_true,
               i_thumb, i_pc, i_target, i_taken,
        input  o_clear_from_alu, o_confirm_from_alu, o_pc_from_alu, o_taken,
               o_redirect_pc, o_branch_cnt, o_mispredict_cnt
    );

    modport slave (
        input  i_clear_from_writeback, i_data_stall, i_val, i_is_branch, i_cond_true,
               i_thumb, i_pc, i_target, i_taken,
        output o_clear_from_alu, o_confirm_from_alu, o_pc_from_alu, o_taken,
               o_redirect_pc, o_branch_cnt, o_mispredict_cnt
    );
endinterface

// File: rtl/zap_branch_resolve.sv
// Branch resolution: compares carried prediction with the resolved condition, pulses clear/confirm.
// Latency 1 cycle input->pulse; i_data_stall freezes every register, writeback clear overrides stall.
module zap_branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    zap_branch_resolve_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             clear_q, clear_d;
    logic             confirm_q, confirm_d;
    logic [31:0]      pc_q, pc_d;
    logic [1:0]       taken_q, taken_d;
    logic [31:0]      redirect_q, redirect_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic             resolve;
    logic             mispredict;
    logic [31:0]      fall_through;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // The upper predictor bit is the predicted direction (WT/ST predict taken).
    assign resolve      = (state_q == ST_IDLE) && bus.i_val && bus.i_is_branch;
    assign mispredict   = bus.i_taken[1] != bus.i_cond_true;
    assign fall_through = bus.i_pc + (bus.i_thumb ? 32'd2 : 32'd4);

    always_comb begin
        state_d          = state_q;
        clear_d          = clear_q;
        confirm_d        = confirm_q;
        pc_d             = pc_q;
        taken_d          = taken_q;
        redirect_d       = redirect_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        if (bus.i_clear_from_writeback) begin
            state_d    = ST_IDLE;
            clear_d    = 1'b0;
            confirm_d  = 1'b0;
            pc_d       = 32'd0;
            taken_d    = 2'd0;
            redirect_d = 32'd0;
        end else if (!bus.i_data_stall) begin
            // Pulses live for exactly one non-stall cycle; SHADOW always returns to IDLE.
            state_d   = ST_IDLE;
            clear_d   = 1'b0;
            confirm_d = 1'b0;
            if (resolve) begin
                pc_d         = bus.i_pc;
                taken_d      = bus.i_taken;
                branch_cnt_d = sat_inc(branch_cnt_q);
                if (mispredict) begin
                    clear_d          = 1'b1;
                    state_d          = ST_SHADOW;
                    redirect_d       = bus.i_cond_true ? bus.i_target : fall_through;
                    mispredict_cnt_d = sat_inc(mispredict_cnt_q);
                end else begin
                    confirm_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q          <= ST_IDLE;
            clear_q          <= 1'b0;
            confirm_q        <= 1'b0;
            pc_q             <= 32'd0;
            taken_q          <= 2'd0;
            redirect_q       <= 32'd0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            clear_q          <= clear_d;
            confirm_q        <= confirm_d;
            pc_q             <= pc_d;
            taken_q          <= taken_d;
            redirect_q       <= redirect_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.o_clear_from_alu   = clear_q;
    assign bus.o_confirm_from_alu = confirm_q;
    assign bus.o_pc_from_alu      = pc_q;
    assign bus.o_taken            = taken_q;
    assign bus.o_redirect_pc      = redirect_q;
    assign bus.o_branch_cnt       = branch_cnt_q;
    assign bus.o_mispredict_cnt   = mispredict_cnt_q;

endmodule
